xor_arbiter: RTL and testbench
==============================

XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters sharing the XOR datapath (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N bits: per-requester request, held high until that requester's ack.
REQ-006 The block SHALL have port a_in, input, N*WIDTH bits: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port b_in, input, N*WIDTH bits: operand B, packed the same way as a_in.
REQ-008 The block SHALL have port ack, output, N bits: one-cycle pulse, operands of requester i captured.
REQ-009 The block SHALL have port done, output, N bits: one-cycle pulse, result for requester i valid on d_out.
REQ-010 The block SHALL have port d_out, output, WIDTH bits: the registered result A XOR B.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-013 IDLE, any req bit high at a rising edge: grant one index g, latch a_in/b_in slice g into operand registers, go to EXEC.
REQ-014 Round-robin: the search SHALL start at pointer ptr and ascend modulo N; the first set req bit wins.
REQ-015 IDLE, req all zero: remain in IDLE; no outputs change.
REQ-016 ack[g] SHALL be high for exactly the cycle following the capture edge (EXEC cycle); all other ack bits SHALL be 0.
REQ-017 EXEC: at the next edge the result register SHALL load op_a XOR op_b (bitwise, WIDTH bits, no carry); the FSM SHALL go to DONE.
REQ-018 DONE: done[g] SHALL be high for exactly that cycle with d_out equal to the new result.
REQ-019 At the next edge the FSM SHALL return to IDLE and ptr SHALL become (g+1) mod N, wrapping N-1 to 0.
REQ-020 Latency: capture edge k, ack during cycle k..k+1, done during cycle k+1..k+2; earliest next capture at edge k+3.
REQ-021 d_out SHALL hold its last result until the next DONE; it SHALL NOT follow the operand inputs.
REQ-022 Operand changes and req deassertion after the capture edge SHALL NOT affect the in-flight operation; done is still issued.
REQ-023 A req bit still high in IDLE after its done SHALL be treated as a new request and arbitrated normally.
REQ-024 At most one bit of ack and at most one bit of done SHALL be high in any cycle, and never both.
REQ-025 Simultaneous requests SHALL each be granted within N operations; no requester SHALL starve.

Reset
REQ-026 Reset high SHALL immediately force: state IDLE, ptr 0, ack 0, done 0, d_out 0, busy 0, operand registers 0.
REQ-027 Reset during EXEC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After reset deasserts, the first capture SHALL occur at the first rising edge that sees any req bit high.

Verification
REQ-029 Single request: N=4, WIDTH=8, req=0001, a=8'hA5, b=8'h0F -> ack=0001 one cycle later; done=0001 the next cycle with d_out=8'hAA; busy high exactly 2 cycles.
REQ-030 All-request fairness: req=1111 held, each requester reasserting after its done -> grant order 0,1,2,3,0; every done 3 cycles apart.
REQ-031 Wrap-around: ptr=3 (after a grant to 2), req=1001 -> grant 3 first, then 0.
REQ-032 Operand/req change in flight: after ack, change a_in slice to 8'hFF and drop req -> d_out still reflects the captured operands; done still pulses.
REQ-033 Reset mid-operation: assert reset during DONE of requester 1 -> done, ack, d_out, busy go 0 immediately; with req=0010 after release -> requester 1 is granted (ptr=0 search) at the first edge.
REQ-034 Exhaustive identity: WIDTH=8, a=b=8'h3C -> d_out=8'h00; a=8'h00, b=8'hFF -> d_out=8'hFF.

Source files
------------

// File: rtl/xor_arbiter.sv
// xor_arbiter
//   A single registered XOR datapath shared by N requesters under
//   round-robin arbitration. Each grant takes three cycles: capture in IDLE,
//   compute in EXEC, and present the result in DONE. The search pointer then
//   moves past the requester that was just served.
//
// Parameters
//   N      number of requesters (2..8)
//   WIDTH  operand and result width in bits
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   req    [N]        per-requester request, held until its ack
//   a_in   [N*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in   [N*WIDTH]  operand B, same packing as a_in
//   ack    [N]        one-cycle pulse: operands of requester i captured
//   done   [N]        one-cycle pulse: d_out holds requester i's result
//   d_out  [WIDTH]    registered A XOR B, held until the next DONE
//   busy              high whenever the FSM is not in IDLE
module xor_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] a_in,
   input  logic [N*WIDTH-1:0] b_in,
   output logic [N-1:0]       ack,
   output logic [N-1:0]       done,
   output logic [WIDTH-1:0]   d_out,
   output logic               busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    gnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic             found;
   logic [PW-1:0]    pick;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [PW-1:0]    ptr_next;

   function automatic logic [N-1:0] one_hot(input logic [PW-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search: walk upward from ptr and wrap at N; the first set req wins.
   always_comb begin
      int j;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) begin
            j = j - N;
         end else begin
            j = j;
         end
         if (!found && req[j[PW-1:0]]) begin
            found = 1'b1;
            pick  = j[PW-1:0];
         end else begin
            found = found;
         end
      end
   end

   // Operand mux: select the granted requester's slices of a_in and b_in.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N; i++) begin
         if (pick == PW'(i)) begin
            sel_a = a_in[i*WIDTH +: WIDTH];
            sel_b = b_in[i*WIDTH +: WIDTH];
         end else begin
            sel_a = sel_a;
            sel_b = sel_b;
         end
      end
   end

   // Pointer successor of the served requester, wrapping N-1 back to 0.
   always_comb begin
      if (gnt == PW'(N - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = gnt + PW'(1'b1);
      end
   end

   // Control FSM with registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         ptr   <= '0;
         gnt   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         ack   <= '0;
         done  <= '0;
         d_out <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt   <= pick;
                  op_a  <= sel_a;
                  op_b  <= sel_b;
                  ack   <= one_hot(pick);
                  busy  <= 1'b1;
                  state <= S_EXEC;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_EXEC: begin
               ack   <= '0;
               done  <= one_hot(gnt);
               d_out <= op_a ^ op_b;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= '0;
               busy  <= 1'b0;
               ptr   <= ptr_next;
               state <= S_IDLE;
            end
            default: begin
               ack   <= '0;
               done  <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xor_arbiter.sv
// tb_xor_arbiter
//   Self-checking bench for xor_arbiter (N=4, WIDTH=8). A transaction-level
//   model (phase counter, modulo pointer, XOR of the chosen operand slices)
//   predicts ack/done/d_out/busy every cycle; directed sequences pin the
//   model with hand-computed values, then randomized traffic runs.
module tb_xor_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;
   logic [N-1:0]   ack;
   logic [N-1:0]   done;
   logic [W-1:0]   d_out;
   logic           busy;

   xor_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
      .ack(ack), .done(done), .d_out(d_out), .busy(busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // m_phase: 0 = idle, 1 = cycle after capture, 2 = cycle showing the result
   int           m_phase = 0;
   int           m_ptr   = 0;
   int           m_g     = 0;
   int           m_pick;
   logic [W-1:0] m_res   = '0;
   logic [W-1:0] m_dout  = '0;

   function automatic int pick_idx(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[k]) return k;
      end
      return -1;
   endfunction

   assign m_pick = pick_idx(req, m_ptr);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= 0;
         m_ptr   <= 0;
         m_g     <= 0;
         m_res   <= '0;
         m_dout  <= '0;
      end else if (m_phase == 0) begin
         if (m_pick >= 0) begin
            m_g     <= m_pick;
            m_res   <= a_in[m_pick*W +: W] ^ b_in[m_pick*W +: W];
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         m_dout  <= m_res;
         m_phase <= 2;
      end else begin
         m_phase <= 0;
         m_ptr   <= (m_g + 1) % N;
      end
   end

   logic [N-1:0] exp_ack;
   logic [N-1:0] exp_done;
   logic [W-1:0] exp_dout;
   logic         exp_busy;
   assign exp_ack  = (m_phase == 1) ? (N'(1) << m_g) : '0;
   assign exp_done = (m_phase == 2) ? (N'(1) << m_g) : '0;
   assign exp_dout = m_dout;
   assign exp_busy = (m_phase != 0);

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      vectors++;
      if (ack !== exp_ack || done !== exp_done || d_out !== exp_dout || busy !== exp_busy) begin
         miscompares++;
         $display("FAIL cycle_check t=%0t ack=%b want %b done=%b want %b d_out=%h want %h busy=%b want %b",
                  $time, ack, exp_ack, done, exp_done, d_out, exp_dout, busy, exp_busy);
      end
   end

   // ---------------- helpers ----------------
   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
   endtask

   // One isolated request from requester i; checks the done pulse and result.
   task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d);
      req = N'(1) << i;
      set_op(i, a, b);
      step();
      req = '0;
      step();
      @(negedge clk);
      lit("single_done", 32'(done), 32'(N'(1) << i));
      lit("single_dout", 32'(d_out), 32'(exp_d));
      step();
   endtask

   int gq[$];
   int dq[$];

   // Run a fixed number of cycles, logging DUT grants and done cycles;
   // with drop set, each requester releases req once it sees its ack.
   task automatic run(input int maxc, input bit drop);
      gq.delete();
      dq.delete();
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (ack != '0) gq.push_back(idx_of(ack));
         if (done != '0) dq.push_back(c);
         step();
         if (drop) req = req & ~exp_ack;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   int waitc[N];
   int maxwait;

   initial begin
      reset = 1'b1;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(negedge clk);
      lit("reset_ack",  32'(ack),   32'h0);
      lit("reset_done", 32'(done),  32'h0);
      lit("reset_dout", 32'(d_out), 32'h0);
      lit("reset_busy", 32'(busy),  32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single request: A5 ^ 0F = AA, busy for exactly two cycles.
      req = 4'b0001;
      set_op(0, 8'hA5, 8'h0F);
      step();
      req = '0;
      @(negedge clk);
      lit("t1_ack",   32'(ack),  32'h1);
      lit("t1_busy",  32'(busy), 32'h1);
      lit("t1_done0", 32'(done), 32'h0);
      step();
      @(negedge clk);
      lit("t1_done", 32'(done),  32'h1);
      lit("t1_dout", 32'(d_out), 32'hAA);
      lit("t1_ack0", 32'(ack),   32'h0);
      step();
      @(negedge clk);
      lit("t1_idle_busy", 32'(busy),  32'h0);
      lit("t1_hold_dout", 32'(d_out), 32'hAA);

      // XOR identities; these also walk ptr to 3.
      single(1, 8'h3C, 8'h3C, 8'h00);
      single(2, 8'h00, 8'hFF, 8'hFF);

      // Wrap-around: ptr=3, req=1001 -> 3 then 0.
      req = 4'b1001;
      set_op(3, 8'h11, 8'h22);
      set_op(0, 8'h33, 8'h44);
      run(12, 1'b1);
      lit("wrap_count", 32'(gq.size()), 32'd2);
      if (gq.size() == 2) begin
         lit("wrap_first",  32'(gq[0]), 32'd3);
         lit("wrap_second", 32'(gq[1]), 32'd0);
      end

      // All-request fairness from ptr=0.
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      run(15, 1'b0);
      req = '0;
      lit("fair_count", 32'(gq.size()), 32'd5);
      if (gq.size() == 5) begin
         lit("fair_g0", 32'(gq[0]), 32'd0);
         lit("fair_g1", 32'(gq[1]), 32'd1);
         lit("fair_g2", 32'(gq[2]), 32'd2);
         lit("fair_g3", 32'(gq[3]), 32'd3);
         lit("fair_g4", 32'(gq[4]), 32'd0);
      end
      lit("fair_done_count", 32'(dq.size()), 32'd5);
      if (dq.size() == 5) begin
         for (int k = 1; k < 5; k++) lit("fair_done_gap", 32'(dq[k] - dq[k-1]), 32'd3);
      end

      // Operand change and req drop after capture do not disturb the result.
      do_reset();
      req = 4'b0010;
      set_op(1, 8'h12, 8'h34);
      step();
      set_op(1, 8'hFF, 8'h34);
      req = '0;
      @(negedge clk);
      lit("inflight_ack", 32'(ack), 32'h2);
      step();
      @(negedge clk);
      lit("inflight_done", 32'(done),  32'h2);
      lit("inflight_dout", 32'(d_out), 32'h26);
      step();

      // Reset during DONE of requester 1, then re-grant from ptr=0.
      do_reset();
      req = 4'b0010;
      set_op(1, 8'h55, 8'h0F);
      step();
      req = '0;
      step();
      @(negedge clk);
      lit("rst_mid_done_before", 32'(done), 32'h2);
      #1;
      reset = 1'b1;
      #1;
      lit("rst_mid_done", 32'(done),  32'h0);
      lit("rst_mid_ack",  32'(ack),   32'h0);
      lit("rst_mid_dout", 32'(d_out), 32'h0);
      lit("rst_mid_busy", 32'(busy),  32'h0);
      req = 4'b0010;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      lit("rst_no_done", 32'(done), 32'h0);
      step();
      @(negedge clk);
      lit("rst_regrant", 32'(ack), 32'h2);
      req = '0;
      repeat (3) step();

      // Randomized traffic with occasional resets.
      do_reset();
      req = '0;
      maxwait = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (reset) waitc[i] = 0;
            else if (req[i] && !ack[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > maxwait) maxwait = waitc[i];
         end
         for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               set_op(i, W'($urandom), W'($urandom));
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               set_op(i, W'($urandom), W'($urandom));
            end
         end
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;
      lit("no_starvation", 32'(maxwait <= 18), 32'd1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
